// File: rtl/bcd_seg7_mux2_if.sv
// Display-side bus between the BCD counter and the two-digit 7-segment driver.
// The master supplies digits and strobes; the slave drives the multiplexed pins.
interface bcd_seg7_mux2_if;
  logic       upd;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       lz_blank;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  modport master (
    output upd, ones, tens, lz_blank,
    input  seg, an, err
  );

  modport slave (
    input  upd, ones, tens, lz_blank,
    output seg, an, err
  );
endinterface

// File: rtl/bcd_seg7_mux2.sv
// Latches two BCD digits, decodes them to 7-segment patterns and time-multiplexes
// them onto a shared segment bus with optional blank gaps and leading-zero blanking.
module bcd_seg7_mux2 #(
  parameter int unsigned REFRESH_DIV = 4,
  parameter bit          DEAD_EN     = 1'b1,
  parameter bit          POL_LOW     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  bcd_seg7_mux2_if.slave  bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  // Pin-level "off" patterns; XOR with these applies the output polarity.
  localparam logic [6:0] SEG_OFF = POL_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = POL_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_GAP0 = 2'd1,
    S_TENS = 2'd2,
    S_GAP1 = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic             err_q, err_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             tick;
  logic [6:0]       seg_act;
  logic [1:0]       an_act;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_ONES;
      cnt_q   <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      err_q   <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    err_d   = err_q;
    seg_act = 7'h00;
    an_act  = 2'b00;

    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    if (bus.upd) begin
      ones_d = bus.ones;
      tens_d = bus.tens;
      err_d  = err_q | (bus.ones > 4'd9) | (bus.tens > 4'd9);
    end

    if (tick) begin
      case (state_q)
        S_ONES:  state_d = DEAD_EN ? S_GAP0 : S_TENS;
        S_GAP0:  state_d = S_TENS;
        S_TENS:  state_d = DEAD_EN ? S_GAP1 : S_ONES;
        default: state_d = S_ONES;
      endcase
    end

    // Outputs follow the current slot and currently latched digits.
    case (state_q)
      S_ONES: begin
        an_act  = 2'b01;
        seg_act = dec(ones_q);
      end
      S_TENS: begin
        if (!(bus.lz_blank && (tens_q == 4'd0))) begin
          an_act  = 2'b10;
          seg_act = dec(tens_q);
        end
      end
      default: begin
        an_act  = 2'b00;
        seg_act = 7'h00;
      end
    endcase

    seg_d = seg_act ^ SEG_OFF;
    an_d  = an_act ^ AN_OFF;
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;

endmodule
